bundle_fetch: RTL and testbench
===============================

# bundle_fetch

Instruction-fetch bus master between the core sequencer and the memory bus. A one-cycle `doInstructionFetch` pulse carries a bundle address. The block then issues one or more 64-bit read beats, with a request/acknowledge handshake on each beat, and packs the returned 32-bit slot words into one `NFU*32`-bit bundle. Completion is signalled by a one-cycle `doneInstructionFetch` pulse. Functional-unit slot k receives `instruction[32*k +: 32]`.

## Interface
- `NFU`, 2: number of functional-unit slots; bundle is `NFU*4` bytes, legal range 1..8.
- `PHYSICAL_ADDRESS_SIZE`, 56: width of `addrBus`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instructionAddress`  in  64  bundle byte address; sampled only on a `doInstructionFetch` pulse.
- `doInstructionFetch`  in  1  one-cycle start pulse.
- `instruction`  out  NFU*32  assembled bundle; slot 0 in bits [31:0].
- `doneInstructionFetch`  out  1  one-cycle completion pulse.
- `fetchFault`  out  1  valid only with `doneInstructionFetch`; high means the address was rejected.
- `busy`  out  1  high from the cycle after an accepted start through the done cycle.
- `addrBus`  out  PHYSICAL_ADDRESS_SIZE  8-byte-aligned beat address.
- `busRead`  out  1  read request; held high until acknowledged.
- `busAck`  in  1  beat accepted; `dataIn` is valid in the same cycle.
- `dataIn`  in  64  read data, little-endian (low word = lower address).

## Operation
- States:
  - IDLE: waiting for a start pulse.
  - REQ: a beat is outstanding.
  - DONE: one-cycle completion state; returns to IDLE.
- IDLE + `doInstructionFetch`:
  - Latch the address.
  - If `addr[1:0] != 0`, or any bit of `addr[63:PHYSICAL_ADDRESS_SIZE]` is set, go to DONE with the fault flag set. No bus cycle is issued.
  - Otherwise set `addrBus = {addr[PAS-1:3], 3'b0}`, clear the word counter, set the skip flag to `addr[2]`, and go to REQ.
- REQ, `busAck` high:
  - If the skip flag is set: drop the low word, store the high word in slot 0, clear the skip flag.
  - Otherwise store the low word in slot `wc` and the high word in slot `wc+1`. Any word with index ≥ NFU is discarded.
  - `wc` advances by the number of words stored.
  - If `wc` reaches NFU, go to DONE.
  - Otherwise `addrBus += 8` and stay in REQ with `busRead` still high.
- Beat count is `ceil((4*addr[2] + 4*NFU)/8)`. Example: NFU=3 at offset 4 takes 2 beats.
- `addrBus` wraps modulo `2^PHYSICAL_ADDRESS_SIZE`; there is no fault on wrap.
- DONE: pulse `doneInstructionFetch` for one cycle, drive `fetchFault` = fault flag, go to IDLE.
- `doInstructionFetch` outside IDLE is ignored (not queued).
- `instruction` changes only on the done cycle of a non-faulting fetch. On a fault it holds its old value.

## Timing
- Reset values:
  - All outputs 0, including `instruction`.
  - State IDLE.
  - If `rst` is asserted mid-fetch: `busRead` is low on the next cycle, and no done pulse is produced for the aborted fetch.
- Start pulse in cycle T: `busRead` and `addrBus` are valid in T+1.
- An ack in cycle A moves the next beat's address onto `addrBus` in A+1.
- The last ack in cycle A gives `doneInstructionFetch` and the new `instruction` in A+1.
- Minimum latency (NFU=2, aligned, ack immediately): start at T, ack at T+1, done at T+2.
- Fault: done + `fetchFault` in T+1; `busRead` never asserts.
- `busRead` and `addrBus` stay stable while `busAck` is low. There is no timeout.
- `busAck` is ignored outside REQ.
- A start pulse arriving in the done cycle is ignored. The next accepted start is no earlier than DONE+1.

## Structure
- Package `fetch_pkg`:
  - state enum (IDLE/REQ/DONE);
  - constant `SLOT_BYTES = 4`;
  - constant `BEAT_BYTES = 8`;
  - function computing the beat count from NFU and the offset bit.
- One sub-module, `slot_packer`: holds the word counter, skip flag and bundle register, and performs the per-ack word steering. The FSM and address counter stay in `bundle_fetch`.

## Test plan
- NFU=2, address 0x1000, ack immediately, `dataIn = 0xBBBBBBBB_AAAAAAAA` → one beat at 0x1000; done at T+2; `instruction = 0xBBBBBBBB_AAAAAAAA`; `fetchFault` 0.
- NFU=3, address 0x2004, beats return 0x11111111_00000000 then 0x33333333_22222222 → beats at 0x2000 and 0x2008; slot0 = 0x11111111, slot1 = 0x22222222, slot2 = 0x33333333.
- NFU=2, address 0x1002 → done + fault at T+1; `busRead` stays 0; `instruction` unchanged.
- NFU=2, address with bit 60 set (PAS=56) → fault at T+1; no bus cycle.
- Wait states: `busAck` held low 5 cycles → `busRead` and `addrBus` stable for all 5 cycles; done one cycle after the ack; a second `doInstructionFetch` during the wait is ignored (exactly one done pulse).
- `rst` asserted in REQ → next cycle `busRead` = 0, `busy` = 0, `instruction` = 0, no done pulse; a fresh fetch afterwards completes normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction bundle fetch path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: FSM state enum, slot/beat byte sizes, beat-count helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam int unsigned SLOT_BYTES = 4;
    localparam int unsigned BEAT_BYTES = 8;

    // Beats needed to cover a bundle of nfu slots that starts either on a
    // beat boundary (offset_hi = 0) or in the upper half of a beat.
    function automatic int unsigned beat_count(input int unsigned nfu,
                                               input logic        offset_hi);
        int unsigned bytes;
        bytes = (offset_hi ? SLOT_BYTES : 32'd0) + SLOT_BYTES * nfu;
        return (bytes + BEAT_BYTES - 1) / BEAT_BYTES;
    endfunction

endpackage

// File: rtl/slot_packer.sv
// Steers 32-bit words from 64-bit read beats into an NFU-slot bundle.
// Latency: full_o is combinational with the completing ack; instruction_o updates on the next edge.
// Backpressure: none; consumes one beat per ack_i, excess words beyond NFU are dropped.
// Ports: clk/rst (sync, active high); start_i clears the word counter and
//        loads the skip flag from skip_i; ack_i/data_i deliver one beat;
//        full_o flags the beat that completes the bundle; instruction_o is
//        the last completed bundle (slot 0 in the low bits).
module slot_packer
    import fetch_pkg::*;
#(
    parameter int unsigned NFU = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                skip_i,
    input  logic                ack_i,
    input  logic [63:0]         data_i,
    output logic                full_o,
    output logic [NFU*32-1:0]   instruction_o
);

    localparam int unsigned SLOT_W = SLOT_BYTES * 8;
    localparam int unsigned WCW    = $clog2(NFU + 2);

    logic [WCW-1:0]          wc_q,    wc_d;
    logic                    skip_q,  skip_d;
    logic [NFU*SLOT_W-1:0]   work_q,  work_d;
    logic [NFU*SLOT_W-1:0]   instr_q, instr_d;
    int unsigned             stored;
    int unsigned             filled;

    always_comb begin
        wc_d    = wc_q;
        skip_d  = skip_q;
        work_d  = work_q;
        instr_d = instr_q;
        full_o  = 1'b0;
        stored  = 0;
        filled  = 0;

        if (start_i) begin
            wc_d   = '0;
            skip_d = skip_i;
        end else if (ack_i) begin
            if (skip_q) begin
                // Bundle starts in the upper half of the first beat.
                work_d[SLOT_W-1:0] = data_i[63:32];
                skip_d             = 1'b0;
                stored             = 1;
            end else begin
                // Words that land at index >= NFU simply match no slot.
                for (int k = 0; k < int'(NFU); k++) begin
                    if (k == int'(wc_q)) begin
                        work_d[k*SLOT_W +: SLOT_W] = data_i[31:0];
                    end else if (k == int'(wc_q) + 1) begin
                        work_d[k*SLOT_W +: SLOT_W] = data_i[63:32];
                    end
                end
                stored = 2;
            end

            filled = 32'(wc_q) + stored;
            if (filled >= NFU) begin
                wc_d    = WCW'(NFU);
                full_o  = 1'b1;
                // Publish only complete bundles so the output never shows
                // a half-assembled fetch.
                instr_d = work_d;
            end else begin
                wc_d = WCW'(filled);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q    <= '0;
            skip_q  <= 1'b0;
            work_q  <= '0;
            instr_q <= '0;
        end else begin
            wc_q    <= wc_d;
            skip_q  <= skip_d;
            work_q  <= work_d;
            instr_q <= instr_d;
        end
    end

    assign instruction_o = instr_q;

endmodule

// File: rtl/bundle_fetch.sv
// Instruction-fetch bus master: one start pulse fetches an NFU*32-bit bundle over 64-bit read beats.
// Latency: bus request the cycle after start; done the cycle after the last ack (fault: done next cycle).
// Backpressure: busRead/addrBus hold while busAck is low (no timeout); starts outside IDLE are dropped.
// Ports: clk/rst (sync, active high); instructionAddress + doInstructionFetch
//        start a fetch; instruction/doneInstructionFetch/fetchFault report
//        completion; busy spans the fetch; addrBus/busRead/busAck/dataIn
//        form the read-beat handshake to memory.
module bundle_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned NFU                   = 2,
    parameter int unsigned PHYSICAL_ADDRESS_SIZE = 56
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [63:0]                       instructionAddress,
    input  logic                              doInstructionFetch,
    output logic [NFU*32-1:0]                 instruction,
    output logic                              doneInstructionFetch,
    output logic                              fetchFault,
    output logic                              busy,
    output logic [PHYSICAL_ADDRESS_SIZE-1:0]  addrBus,
    output logic                              busRead,
    input  logic                              busAck,
    input  logic [63:0]                       dataIn
);

    localparam int unsigned PAS = PHYSICAL_ADDRESS_SIZE;

    fetch_state_e   state_q, state_d;
    logic [PAS-1:0] addr_q,  addr_d;
    logic           fault_q, fault_d;

    logic addr_bad;
    logic pk_start;
    logic pk_skip;
    logic pk_ack;
    logic pk_full;

    // Reject word-misaligned addresses and anything beyond the physical space.
    always_comb begin
        addr_bad = (instructionAddress[1:0] != 2'b00) ||
                   ((instructionAddress >> PAS) != 64'd0);
    end

    assign pk_ack = (state_q == ST_REQ) && busAck;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        fault_d  = fault_q;
        pk_start = 1'b0;
        pk_skip  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (doInstructionFetch) begin
                    if (addr_bad) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        fault_d  = 1'b0;
                        addr_d   = {instructionAddress[PAS-1:3], 3'b000};
                        pk_start = 1'b1;
                        pk_skip  = instructionAddress[2];
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (busAck) begin
                    if (pk_full) begin
                        state_d = ST_DONE;
                    end else begin
                        // Wraps modulo 2^PAS by construction.
                        addr_d = addr_q + PAS'(BEAT_BYTES);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
        end
    end

    slot_packer #(
        .NFU (NFU)
    ) u_slot_packer (
        .clk           (clk),
        .rst           (rst),
        .start_i       (pk_start),
        .skip_i        (pk_skip),
        .ack_i         (pk_ack),
        .data_i        (dataIn),
        .full_o        (pk_full),
        .instruction_o (instruction)
    );

    assign busRead              = (state_q == ST_REQ);
    assign busy                 = (state_q != ST_IDLE);
    assign doneInstructionFetch = (state_q == ST_DONE);
    assign fetchFault           = (state_q == ST_DONE) && fault_q;
    assign addrBus              = addr_q;

endmodule

// File: tb/tb_bundle_fetch.sv
// Self-checking bench for bundle_fetch with NFU=2 and NFU=3 instances.
// Latency: n/a (testbench).
// Backpressure: bus acks are driven by the bench, including wait states.
module tb_bundle_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // NFU = 2 instance
    logic [63:0] ia2  = '0;
    logic        dif2 = 1'b0;
    logic [63:0] ins2;
    logic        done2, flt2, busy2, br2;
    logic [55:0] ab2;
    logic        ack2 = 1'b0;
    logic [63:0] din2 = '0;

    // NFU = 3 instance
    logic [63:0] ia3  = '0;
    logic        dif3 = 1'b0;
    logic [95:0] ins3;
    logic        done3, flt3, busy3, br3;
    logic [55:0] ab3;
    logic        ack3 = 1'b0;
    logic [63:0] din3 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: beat addresses and bundles expected, in order.
    logic [55:0] exp_addr_q[$];
    logic [95:0] exp_bun_q[$];
    logic [63:0] model_ins2 = '0;

    always #5 clk = ~clk;

    bundle_fetch #(.NFU(2), .PHYSICAL_ADDRESS_SIZE(56)) d2 (
        .clk(clk), .rst(rst), .instructionAddress(ia2), .doInstructionFetch(dif2),
        .instruction(ins2), .doneInstructionFetch(done2), .fetchFault(flt2), .busy(busy2),
        .addrBus(ab2), .busRead(br2), .busAck(ack2), .dataIn(din2)
    );

    bundle_fetch #(.NFU(3), .PHYSICAL_ADDRESS_SIZE(56)) d3 (
        .clk(clk), .rst(rst), .instructionAddress(ia3), .doInstructionFetch(dif3),
        .instruction(ins3), .doneInstructionFetch(done3), .fetchFault(flt3), .busy(busy3),
        .addrBus(ab3), .busRead(br3), .busAck(ack3), .dataIn(din3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (ins2 !== 64'd0) begin n_bad++; $display("FAIL reset_ins2 got=%h want=0", ins2); end
        n_cmp++; if ({done2, flt2, busy2, br2} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl2 got=%b want=0000", {done2, flt2, busy2, br2}); end
        n_cmp++; if (ab2 !== 56'd0) begin n_bad++; $display("FAIL reset_addr2 got=%h want=0", ab2); end
        n_cmp++; if (ins3 !== 96'd0) begin n_bad++; $display("FAIL reset_ins3 got=%h want=0", ins3); end
        n_cmp++; if ({done3, flt3, busy3, br3} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl3 got=%b want=0000", {done3, flt3, busy3, br3}); end
        n_cmp++; if (ab3 !== 56'd0) begin n_bad++; $display("FAIL reset_addr3 got=%h want=0", ab3); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_aligned();
        logic [95:0] eb;
        exp_addr_q.push_back(56'h1000);
        exp_bun_q.push_back(96'h0_BBBBBBBB_AAAAAAAA);
        ia2 = 64'h1000; dif2 = 1'b1;
        step();                                   // T+1
        dif2 = 1'b0;
        n_cmp++; if ({br2, busy2, done2} !== 3'b110) begin n_bad++; $display("FAIL aligned_req got=%b want=110", {br2, busy2, done2}); end
        n_cmp++; if (ab2 !== exp_addr_q[0]) begin n_bad++; $display("FAIL aligned_addr got=%h want=%h", ab2, exp_addr_q[0]); end
        void'(exp_addr_q.pop_front());
        ack2 = 1'b1; din2 = 64'hBBBBBBBB_AAAAAAAA;
        step();                                   // T+2
        ack2 = 1'b0;
        eb = exp_bun_q.pop_front();
        n_cmp++; if ({done2, flt2, br2} !== 3'b100) begin n_bad++; $display("FAIL aligned_done got=%b want=100", {done2, flt2, br2}); end
        n_cmp++; if (ins2 !== eb[63:0]) begin n_bad++; $display("FAIL aligned_ins got=%h want=%h", ins2, eb[63:0]); end
        model_ins2 = eb[63:0];
    endtask

    // Continues from the done cycle left by test_aligned.
    task automatic test_back_to_back();
        ia2 = 64'h7000; dif2 = 1'b1;              // pulse in the done cycle
        step();
        dif2 = 1'b0;
        n_cmp++; if ({done2, busy2, br2} !== 3'b000) begin n_bad++; $display("FAIL b2b_ignored got=%b want=000", {done2, busy2, br2}); end
        exp_addr_q.push_back(56'h7000);
        exp_bun_q.push_back(96'h0_76543210_FEDCBA98);
        ia2 = 64'h7000; dif2 = 1'b1;              // DONE+1: accepted
        step();
        dif2 = 1'b0;
        n_cmp++; if (br2 !== 1'b1) begin n_bad++; $display("FAIL b2b_req got=%b want=1", br2); end
        n_cmp++; if (ab2 !== exp_addr_q[0]) begin n_bad++; $display("FAIL b2b_addr got=%h want=%h", ab2, exp_addr_q[0]); end
        void'(exp_addr_q.pop_front());
        ack2 = 1'b1; din2 = 64'h76543210_FEDCBA98;
        step();
        ack2 = 1'b0;
        n_cmp++; if (done2 !== 1'b1) begin n_bad++; $display("FAIL b2b_done got=%b want=1", done2); end
        n_cmp++; if (ins2 !== exp_bun_q[0][63:0]) begin n_bad++; $display("FAIL b2b_ins got=%h want=%h", ins2, exp_bun_q[0][63:0]); end
        model_ins2 = exp_bun_q[0][63:0];
        void'(exp_bun_q.pop_front());
        step();
    endtask

    task automatic test_offset();
        logic [63:0] beats [2];
        beats[0] = 64'h11111111_00000000;
        beats[1] = 64'h33333333_22222222;
        exp_addr_q.push_back(56'h2000);
        exp_addr_q.push_back(56'h2008);
        exp_bun_q.push_back(96'h33333333_22222222_11111111);
        ia3 = 64'h2004; dif3 = 1'b1;
        step();
        dif3 = 1'b0;
        for (int b = 0; b < 2; b++) begin
            n_cmp++; if ({br3, done3} !== 2'b10) begin n_bad++; $display("FAIL offset_req%0d got=%b want=10", b, {br3, done3}); end
            n_cmp++; if (ab3 !== exp_addr_q[0]) begin n_bad++; $display("FAIL offset_addr%0d got=%h want=%h", b, ab3, exp_addr_q[0]); end
            void'(exp_addr_q.pop_front());
            ack3 = 1'b1; din3 = beats[b];
            step();
            ack3 = 1'b0;
        end
        n_cmp++; if ({done3, flt3, br3} !== 3'b100) begin n_bad++; $display("FAIL offset_done got=%b want=100", {done3, flt3, br3}); end
        n_cmp++; if (ins3 !== exp_bun_q[0]) begin n_bad++; $display("FAIL offset_ins got=%h want=%h", ins3, exp_bun_q[0]); end
        void'(exp_bun_q.pop_front());
        step();
        n_cmp++; if (done3 !== 1'b0) begin n_bad++; $display("FAIL offset_single_pulse got=%b want=0", done3); end
    endtask

    task automatic test_fault();
        logic [63:0] addrs [3];
        addrs[0] = 64'h0000_0000_0000_1002;
        addrs[1] = 64'h1000_0000_0000_1000;       // bit 60, beyond 56-bit space
        addrs[2] = 64'h0000_0000_0000_1001;
        for (int i = 0; i < 3; i++) begin
            ia2 = addrs[i]; dif2 = 1'b1;
            step();                               // T+1
            dif2 = 1'b0;
            n_cmp++; if ({done2, flt2, br2} !== 3'b110) begin n_bad++; $display("FAIL fault%0d_done got=%b want=110", i, {done2, flt2, br2}); end
            n_cmp++; if (ins2 !== model_ins2) begin n_bad++; $display("FAIL fault%0d_ins_held got=%h want=%h", i, ins2, model_ins2); end
            step();
            n_cmp++; if ({done2, flt2, busy2, br2} !== 4'b0000) begin n_bad++; $display("FAIL fault%0d_after got=%b want=0000", i, {done2, flt2, busy2, br2}); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] beats [2];
        beats[0] = 64'hDEAD0001_CAFE0000;
        beats[1] = 64'h99999999_12345678;
        exp_addr_q.push_back(56'hFF_FFFF_FFFF_FFF8);
        exp_addr_q.push_back(56'h00_0000_0000_0000);
        exp_bun_q.push_back(96'h0_12345678_DEAD0001);
        ia2 = 64'h00FF_FFFF_FFFF_FFFC; dif2 = 1'b1;
        step();
        dif2 = 1'b0;
        for (int b = 0; b < 2; b++) begin
            n_cmp++; if (br2 !== 1'b1) begin n_bad++; $display("FAIL wrap_req%0d got=%b want=1", b, br2); end
            n_cmp++; if (ab2 !== exp_addr_q[0]) begin n_bad++; $display("FAIL wrap_addr%0d got=%h want=%h", b, ab2, exp_addr_q[0]); end
            void'(exp_addr_q.pop_front());
            ack2 = 1'b1; din2 = beats[b];
            step();
            ack2 = 1'b0;
        end
        n_cmp++; if ({done2, flt2} !== 2'b10) begin n_bad++; $display("FAIL wrap_done got=%b want=10", {done2, flt2}); end
        n_cmp++; if (ins2 !== exp_bun_q[0][63:0]) begin n_bad++; $display("FAIL wrap_ins got=%h want=%h", ins2, exp_bun_q[0][63:0]); end
        model_ins2 = exp_bun_q[0][63:0];
        void'(exp_bun_q.pop_front());
        step();
    endtask

    task automatic test_wait_states();
        int n_done = 0;
        int n_unstable = 0;
        exp_addr_q.push_back(56'h3008);
        exp_bun_q.push_back(96'h0_0BADF00D_600DCAFE);
        ia2 = 64'h3008; dif2 = 1'b1;
        step();
        dif2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (br2 !== 1'b1 || ab2 !== exp_addr_q[0]) n_unstable++;
            if (done2 === 1'b1) n_done++;
            dif2 = (i == 1);                      // start during REQ must be dropped
            ia2  = 64'h4000;
            step();
        end
        dif2 = 1'b0;
        n_cmp++; if (n_unstable !== 0) begin n_bad++; $display("FAIL wait_stable got=%0d unstable cycles want=0", n_unstable); end
        n_cmp++; if (ab2 !== exp_addr_q[0]) begin n_bad++; $display("FAIL wait_addr got=%h want=%h", ab2, exp_addr_q[0]); end
        void'(exp_addr_q.pop_front());
        ack2 = 1'b1; din2 = 64'h0BADF00D_600DCAFE;
        step();
        ack2 = 1'b0;
        n_cmp++; if (done2 !== 1'b1) begin n_bad++; $display("FAIL wait_done got=%b want=1", done2); end
        n_cmp++; if (ins2 !== exp_bun_q[0][63:0]) begin n_bad++; $display("FAIL wait_ins got=%h want=%h", ins2, exp_bun_q[0][63:0]); end
        model_ins2 = exp_bun_q[0][63:0];
        void'(exp_bun_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            if (done2 === 1'b1) n_done++;
            step();
        end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL wait_done_count got=%0d want=1", n_done); end
        n_cmp++; if ({busy2, br2} !== 2'b00) begin n_bad++; $display("FAIL wait_no_second got=%b want=00", {busy2, br2}); end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        logic [63:0] beats [2];
        beats[0] = 64'hB0B0B0B1_A0A0A0A1;
        beats[1] = 64'hD0D0D0D1_C0C0C0C1;
        ia3 = 64'h5000; dif3 = 1'b1;
        step();
        dif3 = 1'b0;
        n_cmp++; if (br3 !== 1'b1) begin n_bad++; $display("FAIL rstmid_inreq got=%b want=1", br3); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_ins2 = '0;
        n_cmp++; if ({br3, busy3, done3} !== 3'b000) begin n_bad++; $display("FAIL rstmid_ctl got=%b want=000", {br3, busy3, done3}); end
        n_cmp++; if (ins3 !== 96'd0) begin n_bad++; $display("FAIL rstmid_ins got=%h want=0", ins3); end
        for (int i = 0; i < 3; i++) begin
            if (done3 === 1'b1) n_done++;
            step();
        end
        n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL rstmid_no_done got=%0d want=0", n_done); end
        exp_addr_q.push_back(56'h6000);
        exp_addr_q.push_back(56'h6008);
        exp_bun_q.push_back(96'hC0C0C0C1_B0B0B0B1_A0A0A0A1);
        ia3 = 64'h6000; dif3 = 1'b1;
        step();
        dif3 = 1'b0;
        for (int b = 0; b < 2; b++) begin
            n_cmp++; if (ab3 !== exp_addr_q[0]) begin n_bad++; $display("FAIL rstmid_addr%0d got=%h want=%h", b, ab3, exp_addr_q[0]); end
            void'(exp_addr_q.pop_front());
            ack3 = 1'b1; din3 = beats[b];
            step();
            ack3 = 1'b0;
        end
        n_cmp++; if ({done3, flt3} !== 2'b10) begin n_bad++; $display("FAIL rstmid_done got=%b want=10", {done3, flt3}); end
        n_cmp++; if (ins3 !== exp_bun_q[0]) begin n_bad++; $display("FAIL rstmid_ins_new got=%h want=%h", ins3, exp_bun_q[0]); end
        void'(exp_bun_q.pop_front());
        step();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_back_to_back();
        test_offset();
        test_fault();
        test_wrap();
        test_wait_states();
        test_reset_mid();
        n_cmp++; if (exp_addr_q.size() != 0 || exp_bun_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", exp_addr_q.size(), exp_bun_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
